// File: rtl/qrng_uart_tx.sv
// qrng_uart_tx: buffers random bytes from the extractor in a small FIFO and
// sends them on a UART line, 8N1 by default.
// Optional feature macro: QRNG_UART_TX_PARITY_EN (adds an even-parity bit, 8E1).
module qrng_uart_tx #(
    parameter int unsigned CLK_DIV    = 434,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] DATA,
    input  logic       VALID,
    output logic       READY,
    output logic       TXD,
    output logic       BUSY
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [15:0]   BAUD_LAST = 16'(CLK_DIV - 1);

`ifdef QRNG_UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd4
    } state_t;
`endif

    // FIFO storage and pointers
    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;
    logic          fifo_nempty;

    // transmitter
    state_t        state;
    state_t        state_nxt;
    logic [15:0]   baud_cnt;
    logic          bit_end;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          line_lvl;
    logic          txd_q;
    logic          line_active;
`ifdef QRNG_UART_TX_PARITY_EN
    logic          par_q;
`endif

    // READY depends only on the registered occupancy
    assign READY       = (count < DEPTH_C);
    assign push        = VALID && READY && !RST;
    assign fifo_nempty = (count != '0);
    assign bit_end     = (baud_cnt == BAUD_LAST);
    assign TXD         = txd_q;
    // line_active covers the cycle where TXD still shows the stop bit after the FSM went idle
    assign BUSY        = (state != ST_IDLE) || fifo_nempty || line_active;

    // FIFO data write (storage needs no reset; occupancy gates its use)
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= DATA;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state, FIFO pop request and line level for the current bit
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        line_lvl  = 1'b1;
        case (state)
            ST_IDLE: begin
                line_lvl = 1'b1;
                if (fifo_nempty) begin
                    pop       = 1'b1;
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                line_lvl = 1'b0;
                if (bit_end) begin
                    state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                line_lvl = shreg[0];
                if (bit_end && (bit_idx == 3'd7)) begin
`ifdef QRNG_UART_TX_PARITY_EN
                    state_nxt = ST_PARITY;
`else
                    state_nxt = ST_STOP;
`endif
                end
            end
`ifdef QRNG_UART_TX_PARITY_EN
            ST_PARITY: begin
                line_lvl = par_q;
                if (bit_end) begin
                    state_nxt = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                line_lvl = 1'b1;
                if (bit_end) begin
                    if (fifo_nempty) begin
                        pop       = 1'b1;
                        state_nxt = ST_START;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // baud timing, bit shifting and registered serial output
    always_ff @(posedge CLK) begin
        if (RST) begin
            txd_q       <= 1'b1;
            line_active <= 1'b0;
            baud_cnt    <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
`ifdef QRNG_UART_TX_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            txd_q       <= line_lvl;
            line_active <= (state != ST_IDLE);
            if (pop) begin
                shreg    <= mem[rd_ptr];
                baud_cnt <= '0;
                bit_idx  <= '0;
`ifdef QRNG_UART_TX_PARITY_EN
                par_q    <= ^mem[rd_ptr];
`endif
            end else if (state != ST_IDLE) begin
                if (bit_end) begin
                    baud_cnt <= '0;
                    if (state == ST_DATA) begin
                        shreg   <= {1'b0, shreg[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                    end
                end else begin
                    baud_cnt <= baud_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_qrng_uart_tx.sv
// Testbench for qrng_uart_tx: randomized and directed byte streams, a
// timing-level reference model and a UART-receiving scoreboard monitor.
module tb_qrng_uart_tx;

    localparam int unsigned D     = 4;
    localparam int unsigned DEPTH = 4;
`ifdef QRNG_UART_TX_PARITY_EN
    localparam int unsigned NB = 11;
`else
    localparam int unsigned NB = 10;
`endif
    localparam int unsigned FRAME = NB * D;

    logic       clk;
    logic       rst;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       txd;
    logic       busy;

    qrng_uart_tx #(.CLK_DIV(D), .FIFO_DEPTH(DEPTH)) dut (
        .CLK  (clk),
        .RST  (rst),
        .DATA (data),
        .VALID(valid),
        .READY(ready),
        .TXD  (txd),
        .BUSY (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // index of the most recent rising edge
    int unsigned now = 0;
    always @(posedge clk) now <= now + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0]  d;
        int unsigned s;
    } exp_t;

    exp_t        exp_q[$];     // frames expected on the line, in order
    int unsigned pend[$];      // pop edges of accepted bytes still buffered
    int unsigned last_end = 0; // edge after the last scheduled frame's stop bit
    bit          checks_on = 0;
    bit          last_rst  = 0;
    bit          acc_flag  = 0;
    int unsigned acc_s     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h edge=%0d", name, act, req, now);
        end
    endtask

    // One cycle of stimulus, issued right after a falling edge.
    // A byte accepted at edge a goes on the line at max(a+2, end of previous frame)
    // and leaves the buffer one edge earlier.
    task automatic step(input logic v, input logic [7:0] d, input logic r);
        int unsigned a;
        int unsigned s;
        while (pend.size() != 0 && pend[0] <= now) void'(pend.pop_front());
        if (checks_on) begin
            check("ready", ready, (pend.size() < DEPTH));
            check("busy", busy, (pend.size() != 0 || now < last_end));
            if (last_rst) check("txd_after_rst", txd, 1'b1);
        end
        valid    = v;
        data     = d;
        rst      = r;
        acc_flag = 0;
        if (r) begin
            pend.delete();
            exp_q.delete();
            last_end  = 0;
            checks_on = 1;
        end else if (v && pend.size() < DEPTH) begin
            a = now + 1;
            s = (a + 2 > last_end) ? a + 2 : last_end;
            last_end = s + FRAME;
            pend.push_back(s - 1);
            exp_q.push_back('{d: d, s: s});
            acc_flag = 1;
            acc_s    = s;
        end
        last_rst = r;
        @(negedge clk);
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step(1'b0, 8'($urandom), 1'b0);
    endtask

    // hold VALID with the byte until the model says it was taken
    task automatic push_hold(input logic [7:0] d, output int unsigned s);
        int unsigned k = 0;
        bit got = 0;
        s = 0;
        while (!got && k < 500) begin
            step(1'b1, d, 1'b0);
            got = acc_flag;
            s   = acc_s;
            k++;
        end
        check("push_accept", got, 1'b1);
    endtask

    task automatic drain();
        int unsigned k = 0;
        while ((exp_q.size() != 0 || now < last_end + 2) && k < 3000) begin
            step(1'b0, 8'($urandom), 1'b0);
            k++;
        end
        check("drain_in_time", (k < 3000), 1'b1);
    endtask

    // Monitor: receive frames off TXD and compare with the scoreboard
    initial begin
        int unsigned n;
        int unsigned fstart;
        logic        samp [FRAME];
        logic [NB-1:0] lvl;
        logic [7:0]  rx;
        bit          stable;
        exp_t        e;
        n = 0;
        fstart = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                n = 0;
            end else if (n == 0) begin
                if (txd === 1'b0) begin
                    fstart  = now;
                    samp[0] = txd;
                    n       = 1;
                end
            end else begin
                samp[n] = txd;
                n++;
                if (n == FRAME) begin
                    n = 0;
                    stable = 1;
                    for (int unsigned b = 0; b < NB; b++) begin
                        lvl[b] = samp[b*D];
                        for (int unsigned k = 1; k < D; k++)
                            if (samp[b*D+k] !== samp[b*D]) stable = 0;
                    end
                    for (int unsigned i = 0; i < 8; i++) rx[i] = lvl[i+1];
                    check("frame_expected", (exp_q.size() != 0), 1'b1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("frame_start_edge", fstart, e.s);
                        check("frame_data", rx, e.d);
                        check("bit_stable", stable, 1'b1);
                        check("start_bit", lvl[0], 1'b0);
                        check("stop_bit", lvl[NB-1], 1'b1);
`ifdef QRNG_UART_TX_PARITY_EN
                        check("parity_bit", lvl[9], ^e.d);
`endif
                    end
                end
            end
        end
    end

    // Stimulus
    initial begin
        int unsigned s;
        int unsigned k;
        rst   = 1'b1;
        valid = 1'b0;
        data  = 8'h00;
        @(negedge clk);

        // reset held 3 cycles with VALID high: nothing accepted, no frame afterwards
        for (int unsigned i = 0; i < 3; i++) step(1'b1, 8'($urandom), 1'b1);
        idle(60);

        // single byte
        step(1'b1, 8'hA5, 1'b0);
        drain();

        // back-pressure: 6 bytes offered continuously
        for (int unsigned i = 0; i < 6; i++) push_hold(8'(i), s);
        drain();

        // reset during bit 3 of 0x3C with more bytes buffered
        push_hold(8'h3C, s);
        push_hold(8'h11, k);
        push_hold(8'h22, k);
        k = 0;
        while (now < s + 4*D + 1 && k < 500) begin
            step(1'b0, 8'h00, 1'b0);
            k++;
        end
        step(1'b0, 8'h00, 1'b1);
        idle(100);

        // first accept right after reset release
        step(1'b1, 8'hFF, 1'b1);
        step(1'b1, 8'h5A, 1'b0);
        drain();

`ifdef QRNG_UART_TX_PARITY_EN
        step(1'b1, 8'h07, 1'b0);
        drain();
`endif

        // randomized traffic with occasional resets
        for (int unsigned i = 0; i < 1500; i++)
            step(($urandom % 3) != 0, 8'($urandom), ($urandom % 400) == 0);
        drain();

        check("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
